serial_frame_rx: RTL
====================

Name: serial_frame_rx

Overview:
- Receives bit-serial frames from the external board controller on serial_data_in/serial_clock_in.
- Each frame carries an 8-bit opcode and a 32-bit data word. The block presents them as the two processor-visible input words: data word to r26, status/opcode word to r27.
- Sits between the FPGA pins and the special-register inputs of the regfile.
- The processor consumes a frame by pulsing ack after it has read r26/r27.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizers on serial_clock_in and serial_data_in (min 2)
TIMEOUT_CYCLES, 50000, system clocks without a serial clock rising edge before a partial frame is discarded
OPCODE_BITS, 8, opcode field width, sent first
DATA_BITS, 32, data field width, sent after the opcode

Ports:
clock  input  1  system clock, all logic on rising edge
reset_not  input  1  asynchronous, active-low reset
serial_data_in  input  1  serial data, asynchronous to clock, valid at serial_clock_in rising edge
serial_clock_in  input  1  serial bit clock from external controller, asynchronous, far slower than clock
ack  input  1  one-cycle pulse from processor: current frame consumed
rx_data  output  32  last accepted data field (feeds r26)
rx_status  output  32  [0] ready, [1] overrun, [15:8] opcode, all other bits 0 (feeds r27)
busy  output  1  high while a frame is partially received

Behaviour:
- Reset (reset_not=0, async):
  - rx_data=0, rx_status=0, busy=0.
  - Shift register, bit counter and timeout counter all cleared; FSM to IDLE.
  - Synchronizer chains cleared to 0.
- Synchronization:
  - Both inputs pass through SYNC_STAGES flops with equal depth, so data stays aligned with clock.
  - A serial edge is a synchronized serial_clock_in rising edge: previous sync value 0, current 1.
  - On an edge, the synchronized data bit is shifted in MSB-first.
- FSM:
  - IDLE: busy=0; counter=0. On edge: shift in bit, counter=1, go to SHIFT.
  - SHIFT: busy=1.
    - On each edge: shift in bit, counter+1, timeout counter cleared.
    - When the edge brings the counter to OPCODE_BITS+DATA_BITS (40), go to COMMIT.
    - With no edge: timeout counter +1. At TIMEOUT_CYCLES, discard the partial frame (shift register and counter cleared) and go to IDLE; outputs unchanged.
  - COMMIT: lasts one cycle, then IDLE.
    - If ready=0 (or ack is high this same cycle): rx_data = low 32 bits of the frame, opcode = high 8 bits, ready=1, overrun=0.
    - Otherwise the new frame is dropped, overrun=1, and rx_data/opcode keep their old values.
- Latency: ready rises exactly SYNC_STAGES+2 clocks after the serial_clock_in rising edge carrying bit 40 (given setup to clock).
- ack:
  - When ack=1 and not in COMMIT: ready=0 and overrun=0 on the next edge. rx_data and opcode hold their values.
  - ack while ready=0 has no effect.
  - ack high for multiple cycles behaves like a single ack.
- Edges arriving in COMMIT are impossible for legal serial rates (edges ≥ SYNC_STAGES+3 clocks apart). Behaviour in that case is undefined; benches must not generate it.
- Bits 40+ never accumulate: the counter is cleared on the COMMIT to IDLE transition.
- A reset mid-frame or mid-COMMIT discards everything. The next edge after reset release starts a fresh frame.

Test Plan:
- Basic frame: send opcode 0x5A, data 0xDEADBEEF (serial period 20 clocks) -> 4 clocks after the 40th serial rising edge, rx_data=0xDEADBEEF, rx_status=0x00005A01, busy=0.
- Ack: after the basic frame, pulse ack for 1 cycle -> rx_status=0x00005A00 next cycle; rx_data stays 0xDEADBEEF; a second ack causes no change.
- Overrun: without ack, send opcode 0x11, data 0x00000001 -> rx_data stays 0xDEADBEEF, rx_status=0x00005A03. Then ack -> 0x00005A00.
- Ack in COMMIT cycle: ready=1, and ack is asserted exactly in COMMIT of a new frame (opcode 0x22, data 0x12345678) -> rx_data=0x12345678, rx_status=0x00002201, no overrun.
- Timeout: send 17 bits, then idle TIMEOUT_CYCLES (set to 100) -> busy drops after 100 idle clocks. A following full frame (0x33/0x0000FFFF) is received correctly: rx_status=0x00003301.
- Reset mid-frame: assert reset_not=0 after 25 bits -> all outputs 0 immediately (async). Release reset and send a full frame 0x44/0xA5A5A5A5 -> rx_data=0xA5A5A5A5, rx_status=0x00004401.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Purpose: deserialises opcode+data frames from a slow asynchronous serial link into r26/r27 words.
// Latency: ready rises SYNC_STAGES+2 clocks after the serial clock edge carrying the last frame bit.
// Backpressure: none on the serial side; an unacknowledged frame blocks new ones, which are dropped and flagged as overrun.
module serial_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int OPCODE_BITS    = 8,
    parameter int DATA_BITS      = 32
) (
    input  logic                 clock,
    input  logic                 reset_not,
    input  logic                 serial_data_in,
    input  logic                 serial_clock_in,
    input  logic                 ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic [31:0]          rx_status,
    output logic                 busy
);

    localparam int FRAME_BITS = OPCODE_BITS + DATA_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);
    localparam int TO_W       = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sclk_sync;
    logic [SYNC_STAGES-1:0]   sdat_sync;
    logic                     sclk_prev;
    logic                     sclk_s;
    logic                     sdat_s;
    logic                     serial_edge;
    logic [FRAME_BITS-1:0]    shreg;
    logic [FRAME_BITS-1:0]    shreg_next;
    logic [CNT_W-1:0]         bit_cnt;
    logic [TO_W-1:0]          to_cnt;
    logic [OPCODE_BITS-1:0]   opcode_q;
    logic                     ready_q;
    logic                     overrun_q;

    // Equal-depth synchronizers keep the data bit aligned with its clock edge.
    always_ff @(posedge clock or negedge reset_not) begin
        if (!reset_not) begin
            sclk_sync <= '0;
            sdat_sync <= '0;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], serial_clock_in};
            sdat_sync <= {sdat_sync[SYNC_STAGES-2:0], serial_data_in};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign sdat_s      = sdat_sync[SYNC_STAGES-1];
    assign serial_edge = sclk_s & ~sclk_prev;
    assign shreg_next  = {shreg[FRAME_BITS-2:0], sdat_s};

    // Frame FSM: shifts bits MSB-first, discards stalled frames, commits full ones to the output words.
    always_ff @(posedge clock or negedge reset_not) begin
        if (!reset_not) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            busy      <= 1'b0;
            rx_data   <= '0;
            opcode_q  <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                    if (serial_edge) begin
                        shreg   <= shreg_next;
                        bit_cnt <= CNT_W'(1);
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (serial_edge) begin
                        shreg   <= shreg_next;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        to_cnt  <= '0;
                        if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                            busy  <= 1'b0;
                            state <= ST_COMMIT;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        // Stalled sender: throw away the partial frame, outputs untouched.
                        shreg   <= '0;
                        bit_cnt <= '0;
                        to_cnt  <= '0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                ST_COMMIT: begin
                    // An ack landing in this cycle frees the slot for the new frame.
                    if (!ready_q || ack) begin
                        rx_data   <= shreg[DATA_BITS-1:0];
                        opcode_q  <= shreg[FRAME_BITS-1:DATA_BITS];
                        ready_q   <= 1'b1;
                        overrun_q <= 1'b0;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                    shreg   <= '0;
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (ack && state != ST_COMMIT) begin
                ready_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    // Status word layout seen by the processor as r27.
    always_comb begin
        rx_status                    = '0;
        rx_status[0]                 = ready_q;
        rx_status[1]                 = overrun_q;
        rx_status[8 +: OPCODE_BITS]  = opcode_q;
    end

endmodule
